// File: rtl/epw22_issue_arbiter.sv
// Round-robin issue arbiter for the EPW22 op/tag/data bus: accepts whole instructions
// from NUM_REQ requesters, serialises them into 1- or 2-beat bus transfers, and limits in-flight result ops.
module epw22_issue_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 2,
  parameter int MAX_OUT    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*4-1:0]          req_op,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_rej,
  input  logic                          ready,
  input  logic                          valid,
  output logic [3:0]                    op,
  output logic [TAG_WIDTH-1:0]          tag,
  output logic [DATA_WIDTH-1:0]         data,
  output logic [3:0]                    outstanding,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  // Handshake: requester i hands over its instruction at a rising edge where
  // req_valid[i] & req_gnt[i]; req_gnt only rises when the bus can take the new beat A.

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT_A = 2'd1, BEAT_B = 2'd2} state_t;

  function automatic logic op_two(input logic [3:0] o);
    return o inside {4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
  endfunction

  function automatic logic op_rsv(input logic [3:0] o);
    return o inside {4'h0, 4'h5, 4'h6, 4'h7};
  endfunction

  function automatic logic op_res(input logic [3:0] o);
    return o inside {4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  state_t                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              cur_op_q;
  logic [TAG_WIDTH-1:0]    cur_tag_q;
  logic [DATA_WIDTH-1:0]   cur_b_q;
  logic [3:0]              op_q, op_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [NUM_REQ-1:0]      elig;
  logic                    found;
  logic [IW-1:0]           sel;
  logic [IW:0]             scan;
  logic [3:0]              sel_op;
  logic [TAG_WIDTH-1:0]    sel_tag;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;
  logic                    can_accept, accept, new_instr, launch_b;
  logic                    inc, dec;

  // Round-robin search beginning at the pointer, skipping credit-blocked result ops.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    sel   = '0;
    scan  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] &
                ~(op_res(req_op[i*4 +: 4]) & (cnt_q == 4'(MAX_OUT)));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
      if (!found && elig[scan[IW-1:0]]) begin
        found = 1'b1;
        sel   = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_tag = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_op  = req_op[i*4 +: 4];
        sel_tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        sel_a   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A pending beat B blocks new accepts; everything else only needs ready.
  assign can_accept = ready & ~reset & ~((state_q == BEAT_A) & op_two(cur_op_q));
  assign accept     = can_accept & found;
  assign new_instr  = accept & ~op_rsv(sel_op);
  assign launch_b   = (state_q == BEAT_A) & op_two(cur_op_q) & ready;

  always_comb begin
    req_gnt = '0;
    req_rej = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_gnt[i] = accept & (sel == IW'(i));
      req_rej[i] = accept & (sel == IW'(i)) & op_rsv(sel_op);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
    end
  end

  assign inc = accept & op_res(sel_op);
  assign dec = valid & (cnt_q != 4'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + 4'd1;
    else if (dec && !inc) cnt_d = cnt_q - 4'd1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (new_instr) state_d = BEAT_A;
      BEAT_A: begin
        if (op_two(cur_op_q)) begin
          if (ready) state_d = BEAT_B;
        end else begin
          state_d = new_instr ? BEAT_A : IDLE;
        end
      end
      BEAT_B:  state_d = new_instr ? BEAT_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the beat to register onto the bus, or NOP.
  always_comb begin
    op_d   = '0;
    tag_d  = '0;
    data_d = '0;
    if (launch_b) begin
      op_d   = cur_op_q;
      tag_d  = cur_tag_q;
      data_d = cur_b_q;
    end else if (new_instr) begin
      op_d   = sel_op;
      tag_d  = sel_tag;
      data_d = sel_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      cur_op_q  <= '0;
      cur_tag_q <= '0;
      cur_b_q   <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      if (new_instr) begin
        cur_op_q  <= sel_op;
        cur_tag_q <= sel_tag;
        cur_b_q   <= sel_b;
      end
    end
  end

  assign op          = op_q;
  assign tag         = tag_q;
  assign data        = data_q;
  assign outstanding = cnt_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_epw22_issue_arbiter.sv
// Bench for epw22_issue_arbiter: directed scenarios plus random traffic, checked cycle by cycle
// against a beat-queue reference model of the issue rules.
module tb_epw22_issue_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int TW = 2;
  localparam int MO = 4;
  localparam int W  = 4 + TW + DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*4-1:0]  req_op;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_gnt, req_rej;
  logic            ready, valid;
  logic [3:0]      op;
  logic [TW-1:0]   tag;
  logic [DW-1:0]   data;
  logic [3:0]      outstanding;
  logic            busy;
  logic [1:0]      dbg_state;

  epw22_issue_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_tag(req_tag),
    .req_a(req_a), .req_b(req_b), .req_gnt(req_gnt), .req_rej(req_rej), .ready(ready),
    .valid(valid), .op(op), .tag(tag), .data(data), .outstanding(outstanding),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit is_two(input logic [3:0] o);
    return o inside {4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
  endfunction
  function automatic bit is_rsv(input logic [3:0] o);
    return o inside {4'h0, 4'h5, 4'h6, 4'h7};
  endfunction
  function automatic bit is_res(input logic [3:0] o);
    return o inside {4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  // Reference model: beats still owed by the current instruction, RR pointer, credit count.
  logic [W-1:0]  exp_q[$];
  int            m_ptr = 0;
  int            m_cnt = 0;
  int            m_rem = 0;
  logic [3:0]    m_op;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_b;
  bit            m_on_bus = 0;
  logic [N-1:0]  acc_mask = '0;

  always @(negedge clk) begin
    logic [N-1:0] eg, er;
    logic [W-1:0] word;
    logic [3:0]   o;
    int           sel, j;
    bit           inc;
    eg = '0; er = '0; word = '0; inc = 0; sel = -1; o = '0;
    chk("outstanding", outstanding, m_cnt);
    chk("busy", busy, ((m_rem != 0) || m_on_bus) ? 1 : 0);
    if (reset) begin
      m_ptr = 0; m_cnt = 0; m_rem = 0;
    end else begin
      if (ready && m_rem > 0) begin
        word  = {m_op, m_tag, m_b};
        m_rem = 0;
      end else if (ready) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (sel < 0 && req_valid[j] && !(is_res(req_op[j*4 +: 4]) && m_cnt == MO)) sel = j;
        end
        if (sel >= 0) begin
          o       = req_op[sel*4 +: 4];
          eg[sel] = 1'b1;
          m_ptr   = (sel + 1) % N;
          inc     = is_res(o);
          if (is_rsv(o)) er[sel] = 1'b1;
          else begin
            word = {o, req_tag[sel*TW +: TW], req_a[sel*DW +: DW]};
            if (is_two(o)) begin
              m_rem = 1;
              m_op  = o;
              m_tag = req_tag[sel*TW +: TW];
              m_b   = req_b[sel*DW +: DW];
            end
          end
        end
      end
      if (inc && !(valid && m_cnt > 0)) m_cnt++;
      else if (!inc && valid && m_cnt > 0) m_cnt--;
    end
    chk("req_gnt", req_gnt, eg);
    chk("req_rej", req_rej, er);
    exp_q.push_back(word);
    m_on_bus = (word[W-1 -: 4] != 4'h0);
    acc_mask = eg;
  end

  // Scoreboard monitor: every cycle the bus presents one word (beat or NOP).
  always @(posedge clk) begin
    logic [W-1:0] w;
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("bus_op_tag_data", {op, tag, data}, w);
    end
  end

  // Driver tasks
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~acc_mask;
    end
  endtask

  task automatic load(input int i, input logic [3:0] o, input logic [TW-1:0] t,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_op[i*4 +: 4]    = o;
    req_tag[i*TW +: TW] = t;
    req_a[i*DW +: DW]   = a;
    req_b[i*DW +: DW]   = b;
    req_valid[i]        = 1'b1;
  endtask

  task automatic send(input int i, input logic [3:0] o, input logic [TW-1:0] t,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    load(i, o, t, a, b);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (acc_mask[i]) begin
        req_valid[i] = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout: requester %0d op %0h not accepted in 40 cycles, required accept", i, o);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ready = 1'b1; valid = 1'b0;
    req_valid = '0; req_op = '0; req_tag = '0; req_a = '0; req_b = '0;
    load(0, 4'h2, 2'd0, 16'h0101, 16'h0);
    load(1, 4'h2, 2'd1, 16'h0202, 16'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run(3);
    req_valid = '0;
    run(2);

    // Two-beat op 3 from requester 0
    send(0, 4'h3, 2'd1, 16'h1234, 16'h0005);
    run(3);

    // Round-robin with both requesters holding op 2
    load(0, 4'h2, 2'd0, 16'hAAAA, 16'h0);
    load(1, 4'h2, 2'd0, 16'h5555, 16'h0);
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    run(2);

    // Ready stall after beat A of op 8
    send(0, 4'h8, 2'd2, 16'h8A8A, 16'h8B8B);
    ready = 1'b0;
    run(3);
    ready = 1'b1;
    run(4);

    // Credit limit: drain, fill to MAX_OUT, then op 9 blocked while op 2 proceeds
    valid = 1'b1;
    for (int c = 0; c < 20 && m_cnt != 0; c++) run(1);
    valid = 1'b0;
    for (int k = 0; k < MO; k++) send(0, 4'h8, TW'(k), 16'h1000 + DW'(k), 16'h2000 + DW'(k));
    load(0, 4'h9, 2'd3, 16'h9999, 16'h9A9A);
    load(1, 4'h2, 2'd1, 16'h2222, 16'h0);
    run(5);
    valid = 1'b1;
    run(1);
    valid = 1'b0;
    run(5);
    req_valid = '0;

    // Reserved op
    send(1, 4'h5, 2'd0, 16'h5A5A, 16'h0);
    run(3);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~acc_mask;
      ready = ($urandom_range(0, 9) < 8);
      valid = ($urandom_range(0, 9) < 3);
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          load(i, 4'($urandom_range(0, 15)), TW'($urandom_range(0, 3)),
               DW'($urandom), DW'($urandom));
      end
    end
    reset = 1'b0; ready = 1'b1; valid = 1'b0; req_valid = '0;
    repeat (6) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
